// File: rtl/e1000_rx_filter.sv
// e1000 receive address filter.
// Holds the first two words of each frame in a small FIFO while the destination
// MAC address is evaluated. Accepted frames are committed to the output side.
// Rejected frames are rewound out of the FIFO and the rest of the frame is
// swallowed. A one-cycle status pulse is produced per frame.
// Optional feature macro: RX_FILTER_STATS_EN (good/drop frame counters).
module e1000_rx_filter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        EN,
  input  logic        UPE,
  input  logic        MPE,
  input  logic        BAM,
  input  logic [31:0] RAL0,
  input  logic [31:0] RAH0,
  input  logic [31:0] mac_s_tdata,
  input  logic [3:0]  mac_s_tkeep,
  input  logic        mac_s_tvalid,
  input  logic        mac_s_tlast,
  output logic        mac_s_tready,
  output logic [31:0] mac_m_tdata,
  output logic [3:0]  mac_m_tkeep,
  output logic        mac_m_tvalid,
  output logic        mac_m_tlast,
  input  logic        mac_m_tready,
  output logic        frame_done,
  output logic        frame_drop,
  output logic [1:0]  drop_reason,
  output logic [15:0] frame_len,
  output logic [31:0] good_cnt,
  output logic [31:0] drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {HDR0, HDR1, PASS, DROP} state_t;

  state_t      state;
  logic [AW:0] wr_ptr, rd_ptr, start_ptr, commit_ptr;
  logic [36:0] mem [FIFO_DEPTH];
  logic [36:0] rd_entry;
  logic [31:0] word0;
  logic [15:0] len_acc;
  logic [1:0]  hold_reason;

  logic        full, in_hs, out_hs;
  logic [2:0]  word_bytes;
  logic [15:0] len_base, len_sat;
  logic [16:0] len_sum;
  logic [47:0] dest, station;
  logic        dec_accept;
  logic [1:0]  dec_reason;
  logic        unused_rah;

  assign unused_rah = ^RAH0[30:16];

  function automatic logic [2:0] keep_bytes(input logic [3:0] k);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++) n = n + {2'b00, k[i]};
    return n;
  endfunction

  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Held low while in reset; DROP swallows words without touching the FIFO.
  assign mac_s_tready = !rst_i && ((state == DROP) || !full);
  assign in_hs  = mac_s_tvalid && mac_s_tready;

  assign rd_entry     = mem[rd_ptr[AW-1:0]];
  assign mac_m_tvalid = (rd_ptr != commit_ptr);
  assign mac_m_tdata  = rd_entry[31:0];
  assign mac_m_tkeep  = rd_entry[35:32];
  assign mac_m_tlast  = mac_m_tvalid && rd_entry[36];
  assign out_hs = mac_m_tvalid && mac_m_tready;

  // Running byte count; the first word of a frame restarts it.
  assign word_bytes = keep_bytes(mac_s_tkeep);
  assign len_base   = (state == HDR0) ? 16'd0 : len_acc;
  assign len_sum    = {1'b0, len_base} + {14'd0, word_bytes};
  assign len_sat    = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  assign dest    = {mac_s_tdata[15:0], word0};
  assign station = {RAH0[15:0], RAL0};

  // Accept/reject decision taken on the second header word.
  always_comb begin
    dec_accept = 1'b0;
    dec_reason = 2'd1;
    if (!EN) begin
      dec_reason = 2'd2;
    end else if (mac_s_tlast) begin
      dec_reason = 2'd3;
    end else begin
      if (dest == 48'hFFFF_FFFF_FFFF)
        dec_accept = BAM || MPE;
      else if (word0[0])
        dec_accept = MPE;
      else
        dec_accept = UPE || (RAH0[31] && (dest == station));
      if (dec_accept) dec_reason = 2'd0;
    end
  end

  // FIFO storage; words seen in DROP are never written.
  always_ff @(posedge clk_i) begin
    if (in_hs && (state != DROP))
      mem[wr_ptr[AW-1:0]] <= {mac_s_tlast, mac_s_tkeep, mac_s_tdata};
  end

  // Frame FSM, pointer management and per-frame status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= HDR0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      start_ptr   <= '0;
      commit_ptr  <= '0;
      word0       <= '0;
      len_acc     <= '0;
      hold_reason <= '0;
      frame_done  <= 1'b0;
      frame_drop  <= 1'b0;
      drop_reason <= '0;
      frame_len   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (out_hs) rd_ptr <= rd_ptr + PTR_ONE;
      if (in_hs) begin
        len_acc <= len_sat;
        if (mac_s_tlast) begin
          frame_done <= 1'b1;
          frame_len  <= len_sat;
        end
        case (state)
          HDR0: begin
            word0 <= mac_s_tdata;
            if (mac_s_tlast) begin
              // Single-word frame: word stays unreferenced since wr_ptr is not advanced.
              frame_drop  <= 1'b1;
              drop_reason <= 2'd3;
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
              state  <= HDR1;
            end
          end
          HDR1: begin
            if (dec_accept) begin
              wr_ptr     <= wr_ptr + PTR_ONE;
              commit_ptr <= wr_ptr + PTR_ONE;
              state      <= PASS;
            end else begin
              wr_ptr      <= start_ptr;
              hold_reason <= dec_reason;
              if (mac_s_tlast) begin
                frame_drop  <= 1'b1;
                drop_reason <= dec_reason;
                state       <= HDR0;
              end else begin
                state <= DROP;
              end
            end
          end
          PASS: begin
            wr_ptr     <= wr_ptr + PTR_ONE;
            commit_ptr <= wr_ptr + PTR_ONE;
            if (mac_s_tlast) begin
              start_ptr   <= wr_ptr + PTR_ONE;
              frame_drop  <= 1'b0;
              drop_reason <= 2'd0;
              state       <= HDR0;
            end
          end
          DROP: begin
            if (mac_s_tlast) begin
              frame_drop  <= 1'b1;
              drop_reason <= hold_reason;
              state       <= HDR0;
            end
          end
          default: state <= HDR0;
        endcase
      end
    end
  end

`ifdef RX_FILTER_STATS_EN
  // Frame counters advance on the registered status pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      good_cnt <= '0;
      drop_cnt <= '0;
    end else if (frame_done) begin
      if (frame_drop) drop_cnt <= drop_cnt + 32'd1;
      else            good_cnt <= good_cnt + 32'd1;
    end
  end
`else
  assign good_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: doc/e1000_rx_filter.md
# e1000_rx_filter

Receive-side address filter between the MAC receive AXI-Stream output and the receive DMA path of the e1000 core. Inspects the destination MAC address in the first two words of each frame, then forwards the frame unchanged or discards it whole. Speculatively buffers header words in a small FIFO and rewinds on reject, so rejected frames never reach the DMA path. Emits a per-frame status pulse for the interrupt and statistics logic.

## Interface
- FIFO_DEPTH, 4: internal word FIFO entries; power of 2, minimum 4.
- clk_i  in  1  block clock (aclk domain).
- rst_i  in  1  asynchronous reset, active-high.
- EN  in  1  receive enable (RCTL.EN).
- UPE  in  1  unicast promiscuous.
- MPE  in  1  multicast promiscuous.
- BAM  in  1  broadcast accept.
- RAL0  in  32  station address bytes 0..3, byte 0 in [7:0].
- RAH0  in  32  [15:0] address bytes 4..5; [31] AV (address valid).
- mac_s_tdata  in  32  input data; byte 0 of word in [7:0].
- mac_s_tkeep  in  4  byte enables; all-ones except on tlast word.
- mac_s_tvalid / mac_s_tlast  in  1  input valid / end of frame.
- mac_s_tready  out  1  input ready.
- mac_m_tdata  out  32; mac_m_tkeep  out  4; mac_m_tvalid  out  1; mac_m_tlast  out  1: output stream to the RX DMA path.
- mac_m_tready  in  1  output ready.
- frame_done  out  1  one-cycle pulse at input tlast handshake.
- frame_drop  out  1  valid with frame_done; 1 = discarded.
- drop_reason  out  2  0 none, 1 address miss, 2 EN low, 3 runt.
- frame_len  out  16  byte count of finished frame, saturating at 0xFFFF.
- good_cnt, drop_cnt  out  32  frame counters (see Configuration).

## Operation
- FIFO pointers: wr_ptr, rd_ptr, start_ptr (frame first entry), commit_ptr. Output reads only entries below commit_ptr.
- FSM states: HDR0, HDR1, PASS, DROP. Reset to HDR0.
- HDR0: on input handshake write word, latch byte count; tlast -> runt drop (rewind), stay HDR0; else -> HDR1.
- HDR1: on handshake write word, evaluate decision combinationally from word0/word1 and current EN/UPE/MPE/BAM/RAL0/RAH0:
  - EN=0 -> reject, reason 2.
  - dest = FF:FF:FF:FF:FF:FF -> accept if BAM or MPE.
  - else dest byte0 bit0 = 1 (multicast) -> accept if MPE.
  - else unicast -> accept if UPE or (AV and dest == {RAH0[15:0],RAL0}).
  - miss -> reason 1. tlast in HDR1 -> runt, reason 3, regardless of address.
  - accept: commit_ptr <= wr_ptr+1; -> PASS (or HDR0 if tlast). Reject: wr_ptr <= start_ptr; -> DROP (or HDR0 if tlast).
- PASS: every written word commits immediately; tlast -> HDR0, start_ptr <= wr_ptr+1.
- DROP: words consumed, not written, mac_s_tready=1; tlast -> HDR0.
- mac_s_tready = !full in HDR0/HDR1/PASS; 1 in DROP.
- Frame length = sum of tkeep ones across all input words; reported for both accepted and dropped frames.
- Config inputs sampled only at the HDR1 decision; changes mid-frame affect next frame.
- Output stream: tdata/tkeep/tlast preserved exactly, no gaps added when FIFO committed data present.

## Timing
- Reset: mac_s_tready=0 during rst_i, 1 first cycle after; mac_m_tvalid, mac_m_tlast, frame_done, frame_drop=0; drop_reason=0; frame_len=0; counters=0; all pointers 0.
- Reset mid-frame: all FIFO contents discarded, partial output frame truncated without tlast; downstream also reset.
- Decision registered: first output word mac_m_tvalid earliest 1 cycle after HDR1 handshake.
- PASS throughput: 1 word/cycle when mac_m_tready=1.
- frame_done/status: registered, 1 cycle after tlast handshake.
- Full FIFO during HDR0/HDR1 (previous frame draining): mac_s_tready=0 until space; no words lost.
- Pointer arithmetic modulo FIFO_DEPTH with one extra wrap bit for full/empty.

## Configuration
- RX_FILTER_STATS_EN defined: good_cnt increments on each accepted frame_done, drop_cnt on each dropped one; both 32-bit, wrap at 2^32.
- Undefined: counters not built; good_cnt, drop_cnt tied 0.

## Test plan
- Unicast to RAL0=0x33221100, RAH0=0x80005544, EN=1, 64-byte frame -> 16 words out identical, frame_done with drop=0, len=64.
- Same frame with dest 00:11:22:33:44:66, UPE=0 -> no output words, frame_drop=1, drop_reason=1, len=64; UPE=1 -> forwarded.
- Broadcast 60-byte frame, BAM=0/MPE=0 -> dropped reason 1; BAM=1 -> forwarded, last word tkeep preserved.
- 6-byte frame (tlast on word1, tkeep=0x3) -> dropped reason 3, len=6, next frame forwarded normally.
- Accept frame with mac_m_tready held 0 for 20 cycles, then rejected frame queued behind -> mac_s_tready drops when full, first frame output intact, second never appears.
- EN=0 frame -> reason 2; rst_i pulsed mid-PASS -> all outputs at reset values same cycle; with RX_FILTER_STATS_EN, 3 good + 2 dropped -> good_cnt=3, drop_cnt=2.
